// File: rtl/io_pins_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : io_pins_cmd_ctrl
// Description : Byte-stream command controller for the 16-bank bidirectional
//               I/O pin block. It issues write strobes, returns readback, and
//               owns the direction of each bank.
//               Optional feature macro: IO_CMD_TIMEOUT_EN (GET_DATA timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module io_pins_cmd_ctrl #(
    parameter int STROBE_LEN = 2,
    parameter int SETTLE_LEN = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic [15:0] write_read,
    output logic [7:0]  reg_data_in  [16],
    input  logic [7:0]  reg_data_out [16]
);

    localparam logic [1:0] c_OP_READ    = 2'b00;
    localparam logic [1:0] c_OP_RELEASE = 2'b01;
    localparam logic [1:0] c_OP_WRITE   = 2'b10;
    localparam logic [1:0] c_OP_DRIVE   = 2'b11;

    localparam int                 c_CNT_W       = 16;
    localparam logic [c_CNT_W-1:0] c_STROBE_LAST = c_CNT_W'(STROBE_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LAST = c_CNT_W'(SETTLE_LEN - 1);

    typedef enum logic [2:0] {
        c_IDLE     = 3'd0,
        c_GET_DATA = 3'd1,
        c_PRE      = 3'd2,
        c_STROBE   = 3'd3,
        c_WAIT_RD  = 3'd4,
        c_RESP     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_bank;
    logic [15:0]          r_hold;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [7:0]           r_rsp_data;
    logic                 w_cmd_acc;
    logic                 w_strobe_done;
    logic                 w_settle_done;
    logic                 w_unused;

    generate
        if (STROBE_LEN < 1 || SETTLE_LEN < 1 || TIMEOUT < 1) begin : g_bad_params
            $error("io_pins_cmd_ctrl: STROBE_LEN, SETTLE_LEN and TIMEOUT must be >= 1");
        end
    endgenerate

    assign w_cmd_acc     = cmd_valid && cmd_ready;
    assign w_strobe_done = (r_cnt == c_STROBE_LAST);
    assign w_settle_done = (r_cnt == c_SETTLE_LAST);
    assign rsp_data      = r_rsp_data;
    assign w_unused      = ^cmd_data[5:4];

`ifdef IO_CMD_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(TIMEOUT - 1);
    logic w_timeout;
    // r_cnt clears on entry to GET_DATA, so this fires after TIMEOUT idle cycles
    assign w_timeout = (r_state == c_GET_DATA) && !cmd_valid && (r_cnt == c_TIMEOUT_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        rsp_valid    = 1'b0;
        write_read   = r_hold;
        unique case (r_state)
            c_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    unique case (cmd_data[7:6])
                        c_OP_READ:  w_next_state = c_WAIT_RD;
                        c_OP_WRITE: w_next_state = c_GET_DATA;
                        default:    w_next_state = c_RESP;
                    endcase
                end
            end
            c_GET_DATA: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next_state = c_PRE;
                end
`ifdef IO_CMD_TIMEOUT_EN
                else if (w_timeout) begin
                    w_next_state = c_RESP;
                end
`endif
            end
            c_PRE: begin
                // Guaranteed low level ahead of the load edge
                write_read[r_bank] = 1'b0;
                w_next_state       = c_STROBE;
            end
            c_STROBE: begin
                write_read[r_bank] = 1'b1;
                if (w_strobe_done) begin
                    w_next_state = c_RESP;
                end
            end
            c_WAIT_RD: begin
                if (w_settle_done) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold     <= '1;
            r_bank     <= '0;
            r_cnt      <= '0;
            r_rsp_data <= '0;
            for (int i = 0; i < 16; i++) begin
                reg_data_in[i] <= '0;
            end
        end else begin
            r_cnt <= (w_next_state != r_state) ? '0 : r_cnt + 1'b1;
            unique case (r_state)
                c_IDLE: begin
                    if (w_cmd_acc) begin
                        r_bank <= cmd_data[3:0];
                        if (cmd_data[7:6] == c_OP_RELEASE) begin
                            r_hold[cmd_data[3:0]] <= 1'b1;
                            r_rsp_data            <= cmd_data;
                        end else if (cmd_data[7:6] == c_OP_DRIVE) begin
                            r_hold[cmd_data[3:0]] <= 1'b0;
                            r_rsp_data            <= cmd_data;
                        end
                    end
                end
                c_GET_DATA: begin
                    if (w_cmd_acc) begin
                        reg_data_in[r_bank] <= cmd_data;
                    end
`ifdef IO_CMD_TIMEOUT_EN
                    else if (w_timeout) begin
                        r_rsp_data <= 8'hEE;
                    end
`endif
                end
                c_STROBE: begin
                    if (w_strobe_done) begin
                        r_rsp_data <= reg_data_in[r_bank];
                    end
                end
                c_WAIT_RD: begin
                    if (w_settle_done) begin
                        r_rsp_data <= reg_data_out[r_bank];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_pins_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_io_pins_cmd_ctrl
// Description : Directed self-checking bench for io_pins_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_io_pins_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_data = 8'h00;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [15:0] write_read;
    logic [7:0]  rdi      [16];
    logic [7:0]  rd_model [16];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_pins_cmd_ctrl #(
        .STROBE_LEN (2),
        .SETTLE_LEN (2),
        .TIMEOUT    (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .write_read   (write_read),
        .reg_data_in  (rdi),
        .reg_data_out (rd_model)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after the accept edge
    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) chk("send_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk(tag, 32'(rsp_data), 32'(exp));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] any_rdi;
        for (int i = 0; i < 16; i++) rd_model[i] = 8'h20 + 8'(i);
        rd_model[9]  = 8'hA7;
        rd_model[12] = 8'h6C;
        rd_model[0]  = 8'h3E;

        // Reset and idle
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (5) tick();
        any_rdi = 8'h00;
        for (int i = 0; i < 16; i++) any_rdi = any_rdi | rdi[i];
        chk("rst_write_read", 32'(write_read), 32'hFFFF);
        chk("rst_reg_data_in", 32'(any_rdi), 32'h00);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h00);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // DRIVE bank 3, then WRITE bank 3 with 0x5A
        send_byte(8'hC3);
        chk("drv_lat", 32'(rsp_valid), 32'd1);
        chk("drv_wr", 32'(write_read), 32'hFFF7);
        get_rsp("drv_rsp", 8'hC3);
        send_byte(8'h83);
        send_byte(8'h5A);
        chk("wr3_pre", 32'(write_read), 32'hFFF7);
        chk("wr3_data", 32'(rdi[3]), 32'h5A);
        tick();
        chk("wr3_strobe1", 32'(write_read), 32'hFFFF);
        chk("wr3_norsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("wr3_strobe2", 32'(write_read), 32'hFFFF);
        chk("wr3_norsp2", 32'(rsp_valid), 32'd0);
        tick();
        chk("wr3_restore", 32'(write_read), 32'hFFF7);
        chk("wr3_lat", 32'(rsp_valid), 32'd1);
        get_rsp("wr3_rsp", 8'h5A);

        // RELEASE bank 5, then WRITE bank 5 with 0x3C
        send_byte(8'h45);
        chk("rel5_wr", 32'(write_read), 32'hFFF7);
        get_rsp("rel5_rsp", 8'h45);
        send_byte(8'h85);
        send_byte(8'h3C);
        chk("wr5_pre", 32'(write_read), 32'hFFD7);
        tick();
        chk("wr5_strobe1", 32'(write_read), 32'hFFF7);
        tick();
        chk("wr5_strobe2", 32'(write_read), 32'hFFF7);
        tick();
        chk("wr5_stay_high", 32'(write_read), 32'hFFF7);
        get_rsp("wr5_rsp", 8'h3C);
        chk("wr5_data", 32'(rdi[5]), 32'h3C);
        chk("wr5_other", 32'(rdi[3]), 32'h5A);

        // READ bank 9, response held under back-pressure
        send_byte(8'h09);
        chk("rd9_c1_vld", 32'(rsp_valid), 32'd0);
        chk("rd9_c1_rdy", 32'(cmd_ready), 32'd0);
        tick();
        chk("rd9_c2_vld", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd9_c3_vld", 32'(rsp_valid), 32'd1);
        chk("rd9_c3_data", 32'(rsp_data), 32'hA7);
        rd_model[9] = 8'h11;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rd9_hold_data", 32'(rsp_data), 32'hA7);
            chk("rd9_hold_rdy", 32'(cmd_ready), 32'd0);
        end
        get_rsp("rd9_rsp", 8'hA7);

        // Reset during STROBE of bank 12
        send_byte(8'h8C);
        send_byte(8'h11);
        tick();
        chk("wr12_strobe", 32'(write_read[12]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_wr", 32'(write_read), 32'hFFFF);
        chk("mid_rst_rdy", 32'(cmd_ready), 32'd1);
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_rdi12", 32'(rdi[12]), 32'h00);
        send_byte(8'h0C);
        get_rsp("rd12_rsp", 8'h6C);

        // Boundary banks 15 and 0
        send_byte(8'hCF);
        get_rsp("drv15_rsp", 8'hCF);
        send_byte(8'hC0);
        get_rsp("drv0_rsp", 8'hC0);
        chk("drv15_0_wr", 32'(write_read), 32'h7FFE);
        send_byte(8'h00);
        get_rsp("rd0_rsp", 8'h3E);

`ifdef IO_CMD_TIMEOUT_EN
        begin
            int  n = 1;
            logic saw_low = 1'b0;
            send_byte(8'h81);
            while (!rsp_valid && n < 40) begin
                if (write_read[1] !== 1'b1) saw_low = 1'b1;
                tick();
                n++;
            end
            chk("tmo_lat", 32'(n), 32'd17);
            chk("tmo_no_edge", 32'(saw_low), 32'd0);
            chk("tmo_rdi1", 32'(rdi[1]), 32'h00);
            get_rsp("tmo_rsp", 8'hEE);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
